rgb_breathe_array: RTL
======================

Name: rgb_breathe_array

Overview:
Parametrised multi-channel LED breathing/PWM engine. It is the next generation of the fixed three-colour cycle instances in the board top level. Each of N_CH channels has a runtime speed, a runtime mode and a shared brightness ceiling, and drives one LED through a common PWM carrier. It sits directly behind the PLL clock domain and drives the LED pads; a global sync input re-phases all channels.

Parameters:
N_CH, 3, number of LED channels
PWM_W, 8, PWM carrier / level width in bits (carrier period 2^PWM_W cycles)
SPD_W, 11, width of per-channel speed (prescaler divisor)

Ports:
i_clk  input  1  system clock (PLL output)
i_rst  input  1  synchronous active-high reset
i_speed  input  N_CH*SPD_W  per-channel prescaler divisor; channel k in bits [k*SPD_W +: SPD_W]
i_mode  input  N_CH*2  per-channel mode; 00 off, 01 solid, 10 breathe, 11 blink
i_max_lvl  input  PWM_W  brightness ceiling shared by all channels
i_sync  input  1  single-cycle restart of all channel phases
o_led  output  N_CH  registered PWM output per channel
o_level  output  N_CH*PWM_W  current level per channel
o_peak  output  N_CH  one-cycle pulse when a breathe channel reaches the ceiling

Behaviour:
- The block has one clock and one reset. Reset is synchronous and active-high (i_rst sampled on rising i_clk).
- Reset values: o_led=0, o_level=0, o_peak=0, every prescaler=0, every direction=up, PWM carrier=0.
- Carrier: a free-running PWM_W-bit counter that wraps 2^PWM_W-1 -> 0 and is shared by all channels.
- Per-channel prescaler counts 0..S-1, where S = i_speed (S=0 is treated as 1). When count >= S-1, the prescaler emits tick and returns to 0.
  - The >= compare makes a speed decrease below the current count produce a tick on the next cycle; there is no lockup.
- Level update (on tick only), by mode:
  - off (00): level forced to 0 on every cycle, not just on tick; direction=up.
  - solid (01): level = i_max_lvl on every cycle.
  - breathe (10): triangle wave.
    - dir up: level+1. When the new level equals i_max_lvl, set dir=down and pulse o_peak for exactly that cycle.
    - dir down: level-1. When the new level equals 0, set dir=up.
  - blink (11): level toggles between 0 and i_max_lvl. Any nonzero level goes to 0.
- Ceiling change: if level > i_max_lvl in breathe or blink, level clamps to i_max_lvl on the next cycle regardless of tick, and dir becomes down. No o_peak is generated on a clamp.
- i_max_lvl=0 in breathe: level holds at 0 and o_peak is never asserted.
- Mode change takes effect on the next cycle. The level is retained unless the new mode forces it (off, solid).
- PWM output: o_led[k] <= (carrier < level_k) is registered, giving 1 cycle latency from the level/carrier state.
  - level=0 gives constant 0.
  - level=2^PWM_W-1 gives low for 1 of 2^PWM_W cycles.
- i_sync: has the same effect as reset on prescalers, levels, directions and carrier. o_led goes 0 on the following cycle and o_peak is cleared.
- Priority: i_rst > i_sync > tick/clamp.
- Arithmetic: level never wraps; increment is blocked at i_max_lvl and decrement is blocked at 0. Prescaler width is SPD_W and it never overflows because S <= 2^SPD_W-1.
- All channels are independent except for the shared carrier, i_max_lvl and i_sync. Channel logic is replicated by a generate loop.

Test Plan:
1. Reset, then ch0 breathe, S=3, max=4: level steps 0->1->2->3->4->3->2->1->0 with one step per 3 cycles. o_peak[0] high exactly one cycle, when the level becomes 4. o_led[0] duty = level/256 per carrier period.
2. ch1 solid, max=128: o_level=128 from the cycle after mode set. o_led[1] high for exactly 128 of every 256 cycles, with 1-cycle latency from the carrier.
3. ch2 breathe at level=200, i_max_lvl dropped to 50: level=50 next cycle and dir=down. No o_peak; the next tick gives 49.
4. ch0 breathe at prescaler count 1000 with S=1301, S changed to 10: tick on the next cycle, then ticks every 10 cycles.
5. All channels mid-breathe, assert i_sync for one cycle while a tick coincides: all levels=0, dir=up, carrier=0, and o_led=0 the next cycle. Then assert i_rst and i_sync together: reset values.
6. ch0 S=0, blink, max=255: level alternates 255/0 on every cycle. ch1 off: o_led[1]=0 and o_level=0 throughout.

Source files
------------

// File: rtl/rgb_breathe_array.sv
// rgb_breathe_array
//   Multi-channel LED breathing / PWM engine. All channels share one free-running
//   PWM carrier, one brightness ceiling and one phase-restart input. Each channel
//   has its own prescaler, level and ramp direction.
//
//   Direction register per channel (1 bit):
//     state | meaning
//     up    | breathe ramp is climbing toward i_max_lvl
//     down  | breathe ramp is falling toward 0
//
// Ports
//   i_clk      system clock (PLL output)
//   i_rst      synchronous active-high reset
//   i_speed    per-channel prescaler divisor, channel k at [k*SPD_W +: SPD_W], 0 acts as 1
//   i_mode     per-channel mode, 00 off / 01 solid / 10 breathe / 11 blink
//   i_max_lvl  brightness ceiling shared by all channels
//   i_sync     single-cycle restart of all channel phases and the carrier
//   o_led      registered PWM output per channel
//   o_level    current level per channel, channel k at [k*PWM_W +: PWM_W]
//   o_peak     one-cycle pulse when a breathe channel ramps up to the ceiling
module rgb_breathe_array #(
    parameter int N_CH  = 3,
    parameter int PWM_W = 8,
    parameter int SPD_W = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CH*SPD_W-1:0]   i_speed,
    input  logic [N_CH*2-1:0]       i_mode,
    input  logic [PWM_W-1:0]        i_max_lvl,
    input  logic                    i_sync,
    output logic [N_CH-1:0]         o_led,
    output logic [N_CH*PWM_W-1:0]   o_level,
    output logic [N_CH-1:0]         o_peak
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BRTH  = 2'b10;

    logic [PWM_W-1:0] carrier_q, carrier_d;

    assign carrier_d = carrier_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_sync) begin
            carrier_q <= '0;
        end else begin
            carrier_q <= carrier_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [SPD_W-1:0] spd;
        logic [SPD_W-1:0] lim;
        logic [1:0]       mode;
        logic             tick;
        logic [SPD_W-1:0] cnt_q, cnt_d;
        logic [PWM_W-1:0] lvl_q, lvl_d;
        logic [PWM_W-1:0] lvl_inc, lvl_dec;
        logic             up_q, up_d;
        logic             peak_q, peak_d;
        logic             led_q;

        assign spd     = i_speed[k*SPD_W +: SPD_W];
        assign mode    = i_mode[k*2 +: 2];
        // Divisor 0 behaves as 1, so the terminal count is 0 in both cases.
        assign lim     = (spd == '0) ? '0 : spd - 1'b1;
        // >= rather than == so a speed cut below the current count ticks at once.
        assign tick    = (cnt_q >= lim);
        assign lvl_inc = lvl_q + 1'b1;
        assign lvl_dec = lvl_q - 1'b1;

        always_comb begin
            cnt_d  = tick ? '0 : cnt_q + 1'b1;
            lvl_d  = lvl_q;
            up_d   = up_q;
            peak_d = 1'b0;
            case (mode)
                MODE_OFF: begin
                    lvl_d = '0;
                    up_d  = 1'b1;
                end
                MODE_SOLID: begin
                    lvl_d = i_max_lvl;
                end
                default: begin
                    if (lvl_q > i_max_lvl) begin
                        // Ceiling lowered under us: clamp without a peak pulse.
                        lvl_d = i_max_lvl;
                        up_d  = 1'b0;
                    end else if (tick) begin
                        if (mode == MODE_BRTH) begin
                            if (up_q) begin
                                if (lvl_q < i_max_lvl) begin
                                    lvl_d = lvl_inc;
                                    if (lvl_inc == i_max_lvl) begin
                                        up_d   = 1'b0;
                                        peak_d = 1'b1;
                                    end
                                end else begin
                                    // Already at the ceiling (e.g. entered from solid): turn around quietly.
                                    up_d = 1'b0;
                                end
                            end else begin
                                if (lvl_q != '0) begin
                                    lvl_d = lvl_dec;
                                    if (lvl_dec == '0) begin
                                        up_d = 1'b1;
                                    end
                                end else begin
                                    up_d = 1'b1;
                                end
                            end
                        end else begin
                            lvl_d = (lvl_q != '0) ? '0 : i_max_lvl;
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (i_rst || i_sync) begin
                cnt_q  <= '0;
                lvl_q  <= '0;
                up_q   <= 1'b1;
                peak_q <= 1'b0;
                led_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                up_q   <= up_d;
                peak_q <= peak_d;
                led_q  <= (carrier_q < lvl_q);
            end
        end

        assign o_led[k]                 = led_q;
        assign o_peak[k]                = peak_q;
        assign o_level[k*PWM_W +: PWM_W] = lvl_q;
    end

endmodule
